muldiv_inverse_seq: RTL
=======================

// Module: muldiv_inverse_seq
// PURPOSE
//  Sequential inverse of the combinational multiplier/divider array: recovers the operand from an array result.
//  Mode 1 (div check): rebuilds dividend = quotient*divisor + remainder by shift-add.
//  Mode 0 (mul check): recovers the multiplicand by restoring division, product / divisor.
//  Sits beside the array in the self-check path; one operation at a time, valid/ready on both sides.
// PARAMETERS
//  QW  8  quotient/product width (iteration count = QW)
//  BW  4  divisor width; only the defaults QW=8, BW=4 are verified
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       operand set valid
//  in_ready   out  1       block idle, can accept
//  in_mode    in   1       1 = reconstruct dividend, 0 = divide product (same sense as array Z)
//  in_word    in   QW      mode1: quotient; mode0: product
//  in_div     in   BW      divisor B
//  in_rem     in   BW      mode1: remainder added after shift-add; ignored in mode0
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_result out  QW+BW   mode1: dividend; mode0: {remainder[BW-1:0], quotient[QW-1:0]}
//  out_err    out  1       divide-by-zero flag, valid with out_valid
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_err=0, count=0.
//  FSM: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after QW iterations; DONE -> IDLE on out_ready.
//  in_ready = (state==IDLE), combinational from state only; operands captured on the accept edge.
//  Accept with in_mode=0 and in_div=0: skip RUN, go to DONE next edge; out_result={BW'h0,QW'hFF..}, out_err=1.
//  RUN, one iteration per edge, count 0..QW-1:
//   mode1: MSB-first shift-add: acc = (acc<<1) + (word[QW-1-count] ? div : 0); acc is QW+BW bits,
//     preloaded to 0; in_rem added in the final iteration. Max 255*15+15=3840 fits 12 bits, no overflow.
//   mode0: restoring division: pr = {pr[BW-1:0], word[QW-1-count]} (BW+1 bits);
//     if pr>=div: pr-=div, q bit=1, else q bit=0. Final pr[BW-1:0] is remainder.
//  Latency: out_valid high exactly QW edges after the accepting edge (8 cycles); div-zero: 1 cycle.
//  DONE: out_valid=1, out_result/out_err stable until out_ready sampled high; held indefinitely otherwise.
//  DONE with out_ready=1: out_valid falls next edge, in_ready rises same edge; no same-cycle re-accept
//   (throughput one op per QW+2 cycles).
//  in_valid during RUN/DONE ignored; producer must hold it. Operand changes after accept have no effect.
//  out_result/out_err retain last value in IDLE (undefined to consumer when out_valid=0).
//  rst_n low mid-RUN or mid-DONE: immediate return to reset values; partial result discarded, no out_valid.
//  count wraps never: exits RUN when count==QW-1 on that edge.
// STRUCTURE
//  Shared package muldiv_pkg: state enum {IDLE,RUN,DONE}, MODE_DIV_CHECK=1, MODE_MUL_CHECK=0,
//   QW/BW defaults, DIVZERO_RESULT constant.
//  One sub-module muldiv_addsub_step: BW+1-bit add/compare-subtract cell, pure combinational,
//   selected by mode; top holds FSM, counter, operand/accumulator registers, handshake.
// TESTING
//  mode1 Q=8'h2A,B=4'h5,R=4'h3 -> out_result=12'h0D5, out_err=0, out_valid 8 cycles after accept.
//  mode0 P=8'hD2,B=4'h7 -> out_result=12'h01E (q=30,r=0); P=8'hC8,B=4'hD -> 12'h50F (q=15,r=5).
//  mode1 Q=8'hFF,B=4'hF,R=4'hF -> 12'hF00; mode0 P=8'h05,B=4'hF -> 12'h500 (q=0,r=5).
//  mode0 B=0, P=8'h33 -> out_err=1, out_result=12'h0FF, out_valid 1 cycle after accept.
//  out_ready low 5 cycles in DONE -> out_valid/out_result stable, in_ready=0; then one-cycle handshake, in_ready=1.
//  rst_n pulsed low at RUN iteration 4 -> in_ready=1, out_valid=0 immediately; next op result correct.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential inverse of the multiplier/divider array.
// Pure declarations: no latency, no handshake.
package muldiv_pkg;

    localparam int QW_DEF = 8;
    localparam int BW_DEF = 4;

    localparam logic MODE_DIV_CHECK = 1'b1;
    localparam logic MODE_MUL_CHECK = 1'b0;

    localparam logic [QW_DEF+BW_DEF-1:0] DIVZERO_RESULT = {{BW_DEF{1'b0}}, {QW_DEF{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_addsub_step.sv
// One iteration cell: add (div check) or compare-and-restore-subtract (mul check).
// Combinational, zero latency; no handshake.
module muldiv_addsub_step
    import muldiv_pkg::*;
#(
    parameter int BW = BW_DEF
) (
    input  logic          mode_i,
    input  logic [BW:0]   a_i,
    input  logic [BW-1:0] b_i,
    output logic [BW:0]   res_o,
    output logic          flag_o
);

    logic [BW+1:0] sum;
    logic          ge;

    always_comb begin
        sum    = {1'b0, a_i} + {2'b00, b_i};
        ge     = (a_i >= {1'b0, b_i});
        res_o  = a_i;
        flag_o = 1'b0;
        if (mode_i == MODE_DIV_CHECK) begin
            // flag carries out of the low slice into the upper accumulator bits
            res_o  = sum[BW:0];
            flag_o = sum[BW+1];
        end else begin
            res_o  = ge ? (a_i - {1'b0, b_i}) : a_i;
            flag_o = ge;
        end
    end

endmodule

// File: rtl/muldiv_inverse_seq.sv
// Rebuilds dividend (mode 1) or divides product (mode 0), one bit per cycle; result QW edges after accept
// (1 edge on divide-by-zero). Single op in flight: in_ready only in IDLE, result held until out_ready.
module muldiv_inverse_seq
    import muldiv_pkg::*;
#(
    parameter int QW = QW_DEF,
    parameter int BW = BW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [QW-1:0]    in_word,
    input  logic [BW-1:0]    in_div,
    input  logic [BW-1:0]    in_rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW+BW-1:0] out_result,
    output logic             out_err
);

    localparam int CW = $clog2(QW);

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic              mode_q, mode_d;
    logic              divz_q, divz_d;
    logic [QW-1:0]     word_q, word_d;
    logic [BW-1:0]     div_q, div_d;
    logic [BW-1:0]     rem_q, rem_d;
    logic [QW+BW-1:0]  acc_q, acc_d;
    logic [BW:0]       pr_q, pr_d;
    logic [QW+BW-1:0]  res_q, res_d;
    logic              err_q, err_d;

    logic              cur_bit;
    logic              last_iter;
    logic [QW+BW-1:0]  acc_shift;
    logic [BW:0]       cell_a;
    logic [BW-1:0]     cell_b;
    logic [BW:0]       cell_res;
    logic              cell_flag;
    logic [QW+BW-1:0]  step_acc;
    logic [BW:0]       step_pr;

    // Operand word shifts left each iteration, so its MSB is always the current bit.
    assign cur_bit   = word_q[QW-1];
    assign last_iter = (count_q == CW'(QW-1));
    assign acc_shift = acc_q << 1;

    always_comb begin
        if (mode_q == MODE_DIV_CHECK) begin
            cell_a = acc_shift[BW:0];
            cell_b = cur_bit ? div_q : '0;
        end else begin
            cell_a = {pr_q[BW-1:0], cur_bit};
            cell_b = div_q;
        end
    end

    muldiv_addsub_step #(.BW(BW)) u_step (
        .mode_i (mode_q),
        .a_i    (cell_a),
        .b_i    (cell_b),
        .res_o  (cell_res),
        .flag_o (cell_flag)
    );

    always_comb begin
        step_acc = acc_q;
        step_pr  = pr_q;
        if (mode_q == MODE_DIV_CHECK) begin
            step_acc = {acc_shift[QW+BW-1:BW+1] + {{(QW-2){1'b0}}, cell_flag}, cell_res};
            if (last_iter) begin
                step_acc = step_acc + {{QW{1'b0}}, rem_q};
            end
        end else begin
            step_pr  = cell_res;
            step_acc = {acc_q[QW+BW-2:0], cell_flag};
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        divz_d  = divz_q;
        word_d  = word_q;
        div_d   = div_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        pr_d    = pr_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d  = in_mode;
                    word_d  = in_word;
                    div_d   = in_div;
                    rem_d   = in_rem;
                    divz_d  = (in_mode == MODE_MUL_CHECK) && (in_div == '0);
                    acc_d   = '0;
                    pr_d    = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (divz_q) begin
                    res_d   = DIVZERO_RESULT;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_d   = step_acc;
                    pr_d    = step_pr;
                    word_d  = word_q << 1;
                    count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                    if (last_iter) begin
                        res_d   = (mode_q == MODE_DIV_CHECK) ? step_acc
                                                             : {step_pr[BW-1:0], step_acc[QW-1:0]};
                        err_d   = 1'b0;
                        count_d = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            mode_q  <= 1'b0;
            divz_q  <= 1'b0;
            word_q  <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            pr_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            divz_q  <= divz_d;
            word_q  <= word_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            pr_q    <= pr_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign out_err    = err_q;

endmodule
